// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that shares the register bank's single write port among N_REQ
// write-back requesters, with registered bank-write outputs and a starvation watchdog.
module wb_port_arbiter #(
   parameter int N_REQ    = 3,
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     stall_i,
   input  logic [N_REQ-1:0]         req_valid_i,
   input  logic [N_REQ*5-1:0]       req_rd_i,
   input  logic [N_REQ*XLEN-1:0]    req_data_i,
   output logic [N_REQ-1:0]         req_ready_o,
   output logic                     wr_valid_o,
   output logic [4:0]               wr_rd_o,
   output logic [XLEN-1:0]          wr_data_o,
   output logic [NREGS-1:0]         we_onehot_o,
   output logic [$clog2(N_REQ)-1:0] grant_id_o,
   output logic                     starve_err_o
);
   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_WAIT + 2);
   localparam logic [CW-1:0] WAIT_SAT = '1;
   localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);

   logic [GW-1:0]    last_q;
   logic [GW-1:0]    cand_idx [N_REQ];
   logic [N_REQ-1:0] cand_vld;
   logic [4:0]       rd_arr   [N_REQ];
   logic [XLEN-1:0]  data_arr [N_REQ];
   logic             grant_any;
   logic [GW-1:0]    grant_idx;
   logic             grant_en;
   logic [4:0]       sel_rd;
   logic [XLEN-1:0]  sel_data;
   logic [NREGS-1:0] we_d;
   logic [N_REQ-1:0] over_limit;
   logic             starve_d;

   logic             wr_valid_q;
   logic [4:0]       wr_rd_q;
   logic [XLEN-1:0]  wr_data_q;
   logic [NREGS-1:0] we_q;
   logic [GW-1:0]    grant_id_q;
   logic             starve_q;

   genvar gi;

   // Candidate gi is the requester (last+1+gi) mod N_REQ, i.e. search order from the pointer.
   for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [GW:0] sum;
      assign sum           = {1'b0, last_q} + (GW+1)'(gi + 1);
      assign cand_idx[gi]  = (sum >= (GW+1)'(N_REQ)) ? GW'(sum - (GW+1)'(N_REQ)) : sum[GW-1:0];
      assign cand_vld[gi]  = req_valid_i[cand_idx[gi]];
      assign rd_arr[gi]    = req_rd_i[5*gi +: 5];
      assign data_arr[gi]  = req_data_i[XLEN*gi +: XLEN];
   end

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_any && cand_vld[k]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx[k];
         end
      end
   end

   assign grant_en = grant_any && !stall_i && !reset_i;
   assign sel_rd   = rd_arr[grant_idx];
   assign sel_data = data_arr[grant_idx];

   for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = grant_en && (grant_idx == GW'(gi));
   end

   // Register 0 is hardwired zero, so its enable never fires even for an rd=0 transfer.
   for (gi = 0; gi < NREGS; gi++) begin : g_we
      if (gi == 0) begin : g_zero
         assign we_d[gi] = 1'b0;
      end else begin : g_reg
         assign we_d[gi] = (sel_rd == 5'(gi));
      end
   end

   for (gi = 0; gi < N_REQ; gi++) begin : g_wait
      logic [CW-1:0] wait_q;
      logic [CW-1:0] wait_d;

      always_comb begin
         wait_d = '0;
         if (req_valid_i[gi] && !req_ready_o[gi]) begin
            wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + CW'(1);
         end
      end

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            wait_q <= '0;
         end else begin
            wait_q <= wait_d;
         end
      end

      assign over_limit[gi] = (wait_d > CW'(MAX_WAIT));
   end

   assign starve_d = starve_q | (|over_limit);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_q     <= LAST_RST;
         wr_valid_q <= 1'b0;
         wr_rd_q    <= '0;
         wr_data_q  <= '0;
         we_q       <= '0;
         grant_id_q <= '0;
         starve_q   <= 1'b0;
      end else begin
         wr_valid_q <= grant_en;
         we_q       <= grant_en ? we_d : '0;
         starve_q   <= starve_d;
         // Index, data and grant id hold their last values across idle cycles.
         if (grant_en) begin
            wr_rd_q    <= sel_rd;
            wr_data_q  <= sel_data;
            grant_id_q <= grant_idx;
            last_q     <= grant_idx;
         end
      end
   end

   assign wr_valid_o   = wr_valid_q;
   assign wr_rd_o      = wr_rd_q;
   assign wr_data_o    = wr_data_q;
   assign we_onehot_o  = we_q;
   assign grant_id_o   = grant_id_q;
   assign starve_err_o = starve_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model of round-robin arbitration, the write stage and the watchdog.
module tb_wb_port_arbiter;
   localparam int N        = 3;
   localparam int XLEN     = 32;
   localparam int NREGS    = 32;
   localparam int MAX_WAIT = 15;

   logic               clk = 1'b0;
   logic               reset;
   logic               stall;
   logic [N-1:0]       req_valid;
   logic [N*5-1:0]     req_rd;
   logic [N*XLEN-1:0]  req_data;
   logic [N-1:0]       req_ready;
   logic               wr_valid;
   logic [4:0]         wr_rd;
   logic [XLEN-1:0]    wr_data;
   logic [NREGS-1:0]   we_onehot;
   logic [1:0]         grant_id;
   logic               starve_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   int               m_last;
   int               m_wait [N];
   bit               m_starve;
   bit               m_wr_valid;
   logic [4:0]       m_wr_rd;
   logic [XLEN-1:0]  m_wr_data;
   int               m_gid;
   logic [NREGS-1:0] m_we;
   logic [XLEN-1:0]  m_bank [NREGS];
   logic [XLEN-1:0]  bank   [NREGS];

   always #5 clk = ~clk;

   wb_port_arbiter dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .stall_i      (stall),
      .req_valid_i  (req_valid),
      .req_rd_i     (req_rd),
      .req_data_i   (req_data),
      .req_ready_o  (req_ready),
      .wr_valid_o   (wr_valid),
      .wr_rd_o      (wr_rd),
      .wr_data_o    (wr_data),
      .we_onehot_o  (we_onehot),
      .grant_id_o   (grant_id),
      .starve_err_o (starve_err)
   );

   // Bank registers capture on the falling edge from the port outputs.
   always @(negedge clk) begin
      for (int r = 0; r < NREGS; r++) begin
         if (we_onehot[r] === 1'b1) bank[r] <= wr_data;
      end
   end

   function automatic int exp_grant();
      int idx;
      if (reset || stall) return -1;
      for (int off = 1; off <= N; off++) begin
         idx = (m_last + off) % N;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int g;
      r = '0;
      g = exp_grant();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic model_edge();
      int g;
      logic [4:0] rd;
      logic [XLEN-1:0] d;
      g = exp_grant();
      if (reset) begin
         m_last = N - 1;
         for (int i = 0; i < N; i++) m_wait[i] = 0;
         m_starve = 0; m_wr_valid = 0; m_wr_rd = '0; m_wr_data = '0; m_gid = 0; m_we = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && i != g) m_wait[i] = (m_wait[i] < 31) ? m_wait[i] + 1 : 31;
            else m_wait[i] = 0;
            if (m_wait[i] > MAX_WAIT) m_starve = 1;
         end
         if (g >= 0) begin
            rd = req_rd[g*5 +: 5];
            d  = req_data[g*XLEN +: XLEN];
            m_wr_valid = 1; m_wr_rd = rd; m_wr_data = d; m_gid = g; m_last = g;
            m_we = (rd == 0) ? '0 : (NREGS'(1) << rd);
            if (rd != 0) m_bank[rd] = d;
            $display("[TB] %0t write req%0d rd=%0d data=%h", $time, g, rd, d);
         end else begin
            m_wr_valid = 0;
            m_we = '0;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
      req_rd[i*5 +: 5]      = rd;
      req_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; req_valid = '1;
      for (int i = 0; i < N; i++) set_req(i, 5'($urandom_range(1, 31)), $urandom);
      #1;
      n_tests++;
      if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready_comb: got %b expected 000", req_ready); end
      tick(); tick();
      n_tests++;
      if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
      n_tests++;
      if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
      n_tests++;
      if (we_onehot !== '0) begin n_fail++; $display("FAIL reset_we: got %h expected 0", we_onehot); end
      n_tests++;
      if (starve_err !== 1'b0) begin n_fail++; $display("FAIL reset_starve: got %b expected 0", starve_err); end
      n_tests++;
      if (wr_data !== '0 || wr_rd !== '0 || grant_id !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got rd=%0d data=%h gid=%0d expected zeros", wr_rd, wr_data, grant_id);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 3'b001 || req_ready !== exp_ready()) begin
         n_fail++; $display("FAIL reset_first_grant: got %b expected 001", req_ready);
      end
      tick();
      n_tests++;
      if (grant_id !== 2'd0 || wr_valid !== 1'b1) begin
         n_fail++; $display("FAIL reset_first_write: got gid=%0d valid=%b expected gid=0 valid=1", grant_id, wr_valid);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_single_write();
      req_valid = 3'b001;
      set_req(0, 5'd5, 32'hDEADBEEF);
      #1;
      n_tests++;
      if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b expected 001", req_ready); end
      tick();
      req_valid = '0;
      n_tests++;
      if (wr_valid !== 1'b1 || we_onehot !== 32'h0000_0020 || wr_data !== 32'hDEADBEEF || wr_rd !== 5'd5) begin
         n_fail++;
         $display("FAIL single_write: got valid=%b we=%h data=%h rd=%0d expected 1 00000020 deadbeef 5",
                  wr_valid, we_onehot, wr_data, wr_rd);
      end
      tick();
      n_tests++;
      if (bank[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_bank: got %h expected deadbeef", bank[5]); end
      n_tests++;
      if (wr_valid !== 1'b0 || we_onehot !== '0 || wr_data !== 32'hDEADBEEF || wr_rd !== 5'd5) begin
         n_fail++;
         $display("FAIL single_idle_hold: got valid=%b we=%h data=%h rd=%0d expected 0 0 deadbeef 5",
                  wr_valid, we_onehot, wr_data, wr_rd);
      end
   endtask

   task automatic test_round_robin();
      int exp;
      reset = 1'b1; req_valid = '0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 5'($urandom_range(1, 31)), $urandom);
      req_valid = '1;
      for (int c = 0; c < 6; c++) begin
         exp = c % N;
         #1;
         n_tests++;
         if (req_ready !== 3'(1 << exp) || req_ready !== exp_ready()) begin
            n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, 3'(1 << exp));
         end
         tick();
         n_tests++;
         if (grant_id !== 2'(exp) || wr_valid !== 1'b1 || wr_rd !== m_wr_rd || wr_data !== m_wr_data || we_onehot !== m_we) begin
            n_fail++;
            $display("FAIL rr_write[%0d]: got gid=%0d rd=%0d data=%h we=%h expected gid=%0d rd=%0d data=%h we=%h",
                     c, grant_id, wr_rd, wr_data, we_onehot, exp, m_wr_rd, m_wr_data, m_we);
         end
         set_req(exp, 5'($urandom_range(1, 31)), $urandom);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_rd_zero();
      req_valid = 3'b010;
      set_req(1, 5'd0, 32'h0000_1234);
      #1;
      n_tests++;
      if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rd0_ready: got %b expected 010", req_ready); end
      tick();
      req_valid = '0;
      n_tests++;
      if (wr_valid !== 1'b1 || we_onehot !== '0 || wr_rd !== 5'd0 || grant_id !== 2'd1 || wr_data !== 32'h1234) begin
         n_fail++;
         $display("FAIL rd0_write: got valid=%b we=%h rd=%0d gid=%0d data=%h expected 1 0 0 1 1234",
                  wr_valid, we_onehot, wr_rd, grant_id, wr_data);
      end
      tick();
      n_tests++;
      if (bank[0] !== '0) begin n_fail++; $display("FAIL rd0_bank: got %h expected 0", bank[0]); end
   endtask

   task automatic test_stall_starve();
      stall = 1'b1;
      req_valid = 3'b010;
      set_req(1, 5'd9, $urandom);
      for (int c = 1; c <= 17; c++) begin
         #1;
         n_tests++;
         if (req_ready !== 3'b000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 000", c, req_ready); end
         tick();
         n_tests++;
         if (starve_err !== m_starve || (c == 15 && starve_err !== 1'b0) || (c == 16 && starve_err !== 1'b1)) begin
            n_fail++; $display("FAIL stall_starve[%0d]: got %b expected %b", c, starve_err, m_starve);
         end
      end
      stall = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 3'b010) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 010", req_ready); end
      tick();
      req_valid = '0;
      n_tests++;
      if (grant_id !== 2'd1 || wr_valid !== 1'b1 || wr_rd !== 5'd9 || starve_err !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release_write: got gid=%0d valid=%b rd=%0d starve=%b expected 1 1 9 1",
                  grant_id, wr_valid, wr_rd, starve_err);
      end
      tick(); tick();
      n_tests++;
      if (starve_err !== 1'b1) begin n_fail++; $display("FAIL starve_sticky: got %b expected 1", starve_err); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++;
      if (starve_err !== 1'b0) begin n_fail++; $display("FAIL starve_clear: got %b expected 0", starve_err); end
   endtask

   task automatic test_reset_mid();
      req_valid = 3'b010;
      set_req(1, 5'd7, 32'h0000_00AA);
      #1;
      n_tests++;
      if (req_ready !== 3'b010) begin n_fail++; $display("FAIL mid_ready: got %b expected 010", req_ready); end
      tick();
      n_tests++;
      if (wr_valid !== 1'b1 || we_onehot !== 32'h0000_0080 || wr_data !== 32'hAA) begin
         n_fail++; $display("FAIL mid_accept: got valid=%b we=%h data=%h expected 1 00000080 aa", wr_valid, we_onehot, wr_data);
      end
      reset = 1'b1;
      req_valid = 3'b011;
      set_req(0, 5'd3, $urandom);
      set_req(1, 5'd4, $urandom);
      #1;
      n_tests++;
      if (req_ready !== 3'b000) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 000", req_ready); end
      tick();
      n_tests++;
      if (we_onehot !== '0 || wr_valid !== 1'b0 || wr_data !== '0) begin
         n_fail++; $display("FAIL mid_reset_clear: got we=%h valid=%b data=%h expected 0 0 0", we_onehot, wr_valid, wr_data);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_first_grant: got %b expected 001", req_ready); end
      tick();
      n_tests++;
      if (grant_id !== 2'd0 || wr_rd !== 5'd3) begin
         n_fail++; $display("FAIL mid_first_write: got gid=%0d rd=%0d expected 0 3", grant_id, wr_rd);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      int g;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 300; c++) begin
         stall = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               set_req(i, 5'($urandom_range(0, 31)), $urandom);
               req_valid[i] = 1'b1;
            end
         end
         #1;
         g = exp_grant();
         n_tests++;
         if (req_ready !== exp_ready()) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_ready());
         end
         tick();
         n_tests++;
         if (wr_valid !== m_wr_valid || wr_rd !== m_wr_rd || wr_data !== m_wr_data ||
             we_onehot !== m_we || grant_id !== 2'(m_gid) || starve_err !== m_starve) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: got v=%b rd=%0d d=%h we=%h g=%0d s=%b expected v=%b rd=%0d d=%h we=%h g=%0d s=%b",
                     c, wr_valid, wr_rd, wr_data, we_onehot, grant_id, starve_err,
                     m_wr_valid, m_wr_rd, m_wr_data, m_we, m_gid, m_starve);
         end
         if (g >= 0) req_valid[g] = 1'b0;
      end
      stall = 1'b0;
      req_valid = '0;
      tick();
      for (int r = 0; r < NREGS; r++) begin
         n_tests++;
         if (bank[r] !== m_bank[r]) begin
            n_fail++; $display("FAIL rand_bank[%0d]: got %h expected %h", r, bank[r], m_bank[r]);
         end
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
      for (int r = 0; r < NREGS; r++) begin
         bank[r]   = '0;
         m_bank[r] = '0;
      end
      m_last = N - 1;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      m_starve = 0; m_wr_valid = 0; m_wr_rd = '0; m_wr_data = '0; m_gid = 0; m_we = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single_write();
      test_round_robin();
      test_rd_zero();
      test_stall_starve();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back port arbiter for the integer register bank. Shares the bank's single write port among N_REQ write-back requesters (ALU, load unit, multi-cycle mul/div) using round-robin arbitration with a valid/ready handshake. Drives the one-hot per-register write enables and the shared write data into the 32 bank registers, which capture on the falling clock edge. Also flags requesters that wait too long for a grant.

## Interface
- N_REQ, 3, number of write-back requesters; index 0 has highest priority after reset
- XLEN, 32, data width
- NREGS, 32, number of bank registers; register 0 is hardwired zero
- MAX_WAIT, 15, wait-cycle limit before `starve_err` is set
- clk  in  1  clock; arbiter logic on rising edge
- reset  in  1  reset, synchronous, active-high
- stall  in  1  when high, no grant is issued this cycle
- req_valid  in  N_REQ  request valid, one bit per requester
- req_rd  in  N_REQ*5  destination register index; requester i occupies bits [5i+4:5i]
- req_data  in  N_REQ*XLEN  write data; requester i occupies slice i
- req_ready  out  N_REQ  one-hot grant/accept; combinational
- wr_valid  out  1  registered; a write occupies the port this cycle
- wr_rd  out  5  registered destination index
- wr_data  out  XLEN  registered write data to all bank registers
- we_onehot  out  NREGS  registered per-register write enable; bit 0 is always 0
- grant_id  out  $clog2(N_REQ)  registered index of the requester being written
- starve_err  out  1  sticky; set when any requester waits more than MAX_WAIT cycles

## Operation
- **Handshake**
  - A transfer occurs on a rising edge where req_valid[i] and req_ready[i] are both high.
  - Once a requester asserts req_valid, it must hold req_valid, req_rd and req_data stable until accepted.
  - req_ready depends only on req_valid, stall, reset and the pointer, never on itself.
- **Arbitration**
  - Round-robin pointer `last` (reset value N_REQ-1).
  - Search starts at index (last+1) mod N_REQ and wraps. The first valid requester found is granted.
  - At most one req_ready bit is high. All bits are 0 when stall or reset is high, or when no request is valid.
  - On a transfer, `last` is set to the granted index. Otherwise `last` holds.
- **Output stage** (updated on every rising edge)
  - On a transfer: wr_valid=1, wr_rd=req_rd[g], wr_data=req_data[g], grant_id=g, we_onehot=1<<req_rd[g].
  - With no transfer: wr_valid=0, we_onehot=0. wr_rd, wr_data and grant_id hold their last values.
  - A transfer with rd=0 is accepted and consumes the slot: wr_valid=1, we_onehot all 0, and no register changes.
- **Starvation watchdog**
  - Each requester has a wait counter, width $clog2(MAX_WAIT+2), saturating.
  - The counter increments each cycle the requester is valid but not accepted, and clears on acceptance or when valid is low.
  - starve_err is set when any counter exceeds MAX_WAIT. It clears only on reset.
  - With round-robin and no stall, the worst-case wait is N_REQ-1 cycles, so starve_err indicates a persistent stall or a protocol fault.
- **Reset**
  - Every output is 0 while reset is high: wr_valid, wr_rd, wr_data, we_onehot, grant_id, starve_err, req_ready.
  - `last` resets to N_REQ-1 and the wait counters clear.
  - A reset that arrives mid-operation discards any granted-but-unwritten state on the next rising edge. Un-accepted requests are not lost; requesters keep them pending.

## Timing
- Accept-to-write latency:
  - A request accepted at rising edge k drives the outputs during cycle k..k+1.
  - The bank captures at the falling edge mid-cycle, half a cycle after acceptance.
  - A read in the following cycle sees the new value.
- Throughput is one write per cycle. A single continuously valid requester with no competition is accepted every cycle.
- stall is sampled combinationally. A stalled cycle produces wr_valid=0 in the next cycle.
- Simultaneous requests from all N_REQ requesters are all accepted within N_REQ consecutive cycles, in rotating order.

## Test plan
- **Reset:** hold reset 2 cycles with all req_valid=1 → req_ready=000, wr_valid=0, we_onehot=0, starve_err=0. After release, first grant goes to requester 0.
- **Single write:** req_valid=001, rd=5, data=0xDEADBEEF → accepted at edge k. During cycle k+1: wr_valid=1, we_onehot=0x00000020, wr_data=0xDEADBEEF. Bank reg 5 reads 0xDEADBEEF afterwards.
- **Round-robin:** req_valid=111 held, with each requester re-presenting after acceptance → grant order 0,1,2,0,1,2. Each requester is accepted once every 3 cycles.
- **rd=0:** requester 1 sends rd=0, data=0x1234 → accepted, wr_valid=1, we_onehot=0, bank reg 0 stays 0.
- **Stall/starvation:** req_valid=010 with stall=1 for 17 cycles → req_ready=000 throughout and starve_err=1 from cycle 16. Releasing stall grants requester 1, and starve_err stays 1 until reset.
- **Reset mid-operation:** assert reset on the cycle after acceptance of rd=7, data=0xAA → we_onehot=0 on the next edge, `last` returns to 2, and requester 0 wins the first grant after release.
